// File: rtl/test_out_inf_rr.sv
// Output sink that terminates nVCs virtual channels at a router port.
// Accepts at most one due flit per cycle (round-robin), keeps receive and latency statistics.
module test_out_inf_rr #(
    parameter int nVCs      = 2,
    parameter int TS_WIDTH  = 10,
    parameter int CNT_WIDTH = 16,
    parameter int LAT_WIDTH = 24
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [nVCs*TS_WIDTH-1:0]  flit_ts,
    input  logic [nVCs-1:0]           flit_valid,
    input  logic [TS_WIDTH-1:0]       sim_time,
    input  logic                      stall,
    input  logic                      stats_clr,
    output logic [nVCs-1:0]           flit_ack,
    output logic                      ready,
    output logic [nVCs*CNT_WIDTH-1:0] rx_count,
    output logic [LAT_WIDTH-1:0]      lat_sum,
    output logic [TS_WIDTH-1:0]       lat_max
);

    localparam int PTR_W = (nVCs > 1) ? $clog2(nVCs) : 1;

    logic [TS_WIDTH-1:0]  age [nVCs];
    logic [nVCs-1:0]      eligible;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic                 grant_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic [nVCs-1:0]      grant_onehot;
    logic [TS_WIDTH-1:0]  age_g;
    logic [LAT_WIDTH:0]   lat_sum_ext;
    logic [LAT_WIDTH-1:0] lat_sum_next;
    logic [TS_WIDTH-1:0]  lat_max_next;
    logic [CNT_WIDTH-1:0] cnt [nVCs];

    // Modular age with MSB test makes the due check wrap-safe over half the timestamp range.
    // The VC acked last edge still presents its old flit, so it is masked for one cycle.
    always_comb begin
        for (int i = 0; i < nVCs; i++) begin
            age[i]      = sim_time - flit_ts[i*TS_WIDTH +: TS_WIDTH];
            eligible[i] = flit_valid[i] & ~age[i][TS_WIDTH-1] & ~flit_ack[i];
        end
    end

    always_comb begin
        int idx;
        logic [PTR_W-1:0] idx_w;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_w       = '0;
        if (!stall) begin
            for (int k = 0; k < nVCs; k++) begin
                idx = int'(ptr) + k;
                if (idx >= nVCs) begin
                    idx = idx - nVCs;
                end
                idx_w = PTR_W'(idx);
                if (!grant_valid && eligible[idx_w]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx_w;
                end
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < nVCs; i++) begin
            grant_onehot[i] = grant_valid && (grant_idx == PTR_W'(i));
        end
    end

    assign ptr_next = (grant_idx == PTR_W'(nVCs - 1)) ? '0 : grant_idx + 1'b1;
    assign age_g    = age[grant_idx];

    assign lat_sum_ext  = {1'b0, lat_sum} + (LAT_WIDTH + 1)'(age_g);
    assign lat_sum_next = lat_sum_ext[LAT_WIDTH] ? '1 : lat_sum_ext[LAT_WIDTH-1:0];
    assign lat_max_next = (age_g > lat_max) ? age_g : lat_max;

    always_comb begin
        for (int i = 0; i < nVCs; i++) begin
            rx_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flit_ack <= '0;
            ready    <= 1'b0;
            ptr      <= '0;
            lat_sum  <= '0;
            lat_max  <= '0;
            for (int i = 0; i < nVCs; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            flit_ack <= grant_onehot;
            ready    <= ~stall & ~|eligible & ~grant_valid;
            if (grant_valid) begin
                ptr <= ptr_next;
            end
            // A clear coincident with a grant keeps only that flit's contribution.
            if (stats_clr) begin
                for (int i = 0; i < nVCs; i++) begin
                    cnt[i] <= grant_onehot[i] ? CNT_WIDTH'(1) : '0;
                end
                lat_sum <= grant_valid ? LAT_WIDTH'(age_g) : '0;
                lat_max <= grant_valid ? age_g : '0;
            end else if (grant_valid) begin
                for (int i = 0; i < nVCs; i++) begin
                    if (grant_onehot[i] && (cnt[i] != '1)) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
                lat_sum <= lat_sum_next;
                lat_max <= lat_max_next;
            end
        end
    end

endmodule

// File: tb/tb_test_out_inf_rr.sv
// Directed bench for test_out_inf_rr: a 2-VC instance (narrow counters) and a 4-VC instance.
module tb_test_out_inf_rr;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  sim_time;
    logic        stall;
    logic        stats_clr;

    logic [19:0] ts2;
    logic [1:0]  valid2;
    logic [1:0]  ack2;
    logic        ready2;
    logic [5:0]  rx2;
    logic [23:0] lsum2;
    logic [9:0]  lmax2;

    logic [39:0] ts4;
    logic [3:0]  valid4;
    logic [3:0]  ack4;
    logic        ready4;
    logic [63:0] rx4;
    logic [23:0] lsum4;
    logic [9:0]  lmax4;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    test_out_inf_rr #(.nVCs(2), .TS_WIDTH(10), .CNT_WIDTH(3), .LAT_WIDTH(24)) dut2 (
        .clock(clock), .reset(reset), .flit_ts(ts2), .flit_valid(valid2),
        .sim_time(sim_time), .stall(stall), .stats_clr(stats_clr),
        .flit_ack(ack2), .ready(ready2), .rx_count(rx2), .lat_sum(lsum2), .lat_max(lmax2)
    );

    test_out_inf_rr #(.nVCs(4), .TS_WIDTH(10), .CNT_WIDTH(16), .LAT_WIDTH(24)) dut4 (
        .clock(clock), .reset(reset), .flit_ts(ts4), .flit_valid(valid4),
        .sim_time(sim_time), .stall(stall), .stats_clr(stats_clr),
        .flit_ack(ack4), .ready(ready4), .rx_count(rx4), .lat_sum(lsum4), .lat_max(lmax4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0] exp_seq [8];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        reset     = 1'b1;
        sim_time  = 10'd0;
        stall     = 1'b0;
        stats_clr = 1'b0;
        ts2       = '0;
        valid2    = '0;
        ts4       = '0;
        valid4    = '0;
        tick();
        tick();
        check("rst_ack2", 64'(ack2), 64'h0);
        check("rst_ready2", 64'(ready2), 64'h0);
        check("rst_rx2", 64'(rx2), 64'h0);
        check("rst_lsum2", 64'(lsum2), 64'h0);
        check("rst_lmax2", 64'(lmax2), 64'h0);
        check("rst_ack4", 64'(ack4), 64'h0);

        // 1) both VCs due: VC0 then VC1
        reset    = 1'b0;
        valid2   = 2'b11;
        ts2      = {10'd5, 10'd3};
        sim_time = 10'd5;
        tick();
        check("t1_ack_vc0", 64'(ack2), 64'h1);
        check("t1_ready_a", 64'(ready2), 64'h0);
        valid2 = 2'b10;
        tick();
        check("t1_ack_vc1", 64'(ack2), 64'h2);
        check("t1_ready_b", 64'(ready2), 64'h0);
        valid2 = 2'b00;
        tick();
        check("t1_ack_none", 64'(ack2), 64'h0);
        check("t1_ready_c", 64'(ready2), 64'h1);
        check("t1_rx0", 64'(rx2[2:0]), 64'd1);
        check("t1_rx1", 64'(rx2[5:3]), 64'd1);
        check("t1_lsum", 64'(lsum2), 64'd2);
        check("t1_lmax", 64'(lmax2), 64'd2);

        // 2) future flit, then time steps onto it
        valid2   = 2'b01;
        ts2      = {10'd0, 10'd9};
        sim_time = 10'd8;
        tick();
        check("t2_future_ack", 64'(ack2), 64'h0);
        check("t2_future_ready", 64'(ready2), 64'h1);
        sim_time = 10'd9;
        tick();
        check("t2_due_ack", 64'(ack2), 64'h1);
        check("t2_due_ready", 64'(ready2), 64'h0);
        valid2 = 2'b00;
        tick();
        check("t2_after_ready", 64'(ready2), 64'h1);
        check("t2_rx0", 64'(rx2[2:0]), 64'd2);

        // 3) timestamp wrap
        valid2   = 2'b01;
        ts2      = {10'd0, 10'd1020};
        sim_time = 10'd2;
        tick();
        check("t3_wrap_ack", 64'(ack2), 64'h1);
        ts2 = {10'd0, 10'd10};
        tick();
        check("t3_future_ack_a", 64'(ack2), 64'h0);
        check("t3_future_ready", 64'(ready2), 64'h1);
        tick();
        check("t3_future_ack_b", 64'(ack2), 64'h0);
        check("t3_lsum", 64'(lsum2), 64'd8);
        check("t3_lmax", 64'(lmax2), 64'd6);
        check("t3_rx0", 64'(rx2[2:0]), 64'd3);

        // 5) stall
        valid2 = 2'b00;
        stall  = 1'b1;
        tick();
        check("t5_stall_idle_ready", 64'(ready2), 64'h0);
        valid2 = 2'b11;
        ts2    = {10'd2, 10'd2};
        tick();
        check("t5_stall_ack", 64'(ack2), 64'h0);
        check("t5_stall_ready", 64'(ready2), 64'h0);
        tick();
        check("t5_stall_ack_b", 64'(ack2), 64'h0);
        stall = 1'b0;
        tick();
        check("t5_release_ack_ptr", 64'(ack2), 64'h2);
        valid2 = 2'b01;
        tick();
        check("t5_next_ack", 64'(ack2), 64'h1);
        valid2 = 2'b00;
        tick();
        check("t5_ready", 64'(ready2), 64'h1);
        check("t5_rx1", 64'(rx2[5:3]), 64'd2);
        check("t5_rx0", 64'(rx2[2:0]), 64'd4);

        // 6) saturation of a 3-bit counter, single VC at 1 flit per 2 cycles
        valid2 = 2'b01;
        ts2    = {10'd0, 10'd2};
        for (int n = 0; n < 4; n++) begin
            tick();
            check("t6_ack_on", 64'(ack2), 64'h1);
            tick();
            check("t6_ack_masked", 64'(ack2), 64'h0);
        end
        check("t6_rx0_sat", 64'(rx2[2:0]), 64'd7);
        check("t6_lsum_hold", 64'(lsum2), 64'd8);
        stats_clr = 1'b1;
        ts2       = {10'd0, 10'd0};
        tick();
        check("t6_clr_grant_ack", 64'(ack2), 64'h1);
        check("t6_clr_rx0", 64'(rx2[2:0]), 64'd1);
        check("t6_clr_rx1", 64'(rx2[5:3]), 64'd0);
        check("t6_clr_lsum", 64'(lsum2), 64'd2);
        check("t6_clr_lmax", 64'(lmax2), 64'd2);
        valid2 = 2'b00;
        tick();
        check("t6_clr_only_rx", 64'(rx2), 64'h0);
        check("t6_clr_only_lsum", 64'(lsum2), 64'h0);
        check("t6_clr_only_lmax", 64'(lmax2), 64'h0);
        stats_clr = 1'b0;

        // 4) four VCs continuously due
        valid4   = 4'b1111;
        ts4      = '0;
        sim_time = 10'd2;
        for (int n = 0; n < 8; n++) begin
            tick();
            check("t4_rr_ack", 64'(ack4), 64'(exp_seq[n]));
            check("t4_ready", 64'(ready4), 64'h0);
        end
        check("t4_rx", rx4, {16'd2, 16'd2, 16'd2, 16'd2});
        check("t4_lsum", 64'(lsum4), 64'd16);
        check("t4_lmax", 64'(lmax4), 64'd2);

        // reset mid-operation
        reset = 1'b1;
        tick();
        check("mid_rst_ack", 64'(ack4), 64'h0);
        check("mid_rst_rx", rx4, 64'h0);
        check("mid_rst_lsum", 64'(lsum4), 64'h0);
        check("mid_rst_ready", 64'(ready4), 64'h0);
        reset  = 1'b0;
        valid4 = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
